// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold for a single-owner shared resource.
// A grant stays with its owner until it signals done, drops its request, or
// uses up MAX_HOLD cycles. Every release is followed by one bubble cycle in
// which no grant is made, and the search pointer moves past the old owner.
module rr_hold_arbiter #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   i_req,
  input  logic [N-1:0]   i_done,
  output logic [N-1:0]   o_gnt,
  output logic           o_gnt_valid,
  output logic [IDW-1:0] o_gnt_id,
  output logic           o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam logic [IDW:0]   N_W       = (IDW+1)'(N);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);
  localparam logic [7:0]     HOLD_LIM  = 8'(MAX_HOLD);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic             timeout_q, timeout_d;

  // Selection signals
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic             sel_found;
  logic [IDW:0]     sel_sum;
  logic [IDW-1:0]   sel_id;

  // Owner view: only the current owner's request/done bits matter
  logic             owner_req;
  logic             owner_done;
  logic [IDW-1:0]   ptr_next;

  assign owner_req  = |(i_req  & gnt_q);
  assign owner_done = |(i_done & gnt_q);
  assign ptr_next   = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IDW'(1);

  // Rotate requests so the pointer sits at bit 0, then pick the lowest set bit
  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    req_dbl   = {i_req, i_req} >> ptr_q;
    req_rot   = req_dbl[N-1:0];
    sel_found = 1'b0;
    sel_sum   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sel_found = 1'b1;
        sel_sum   = {1'b0, ptr_q} + (IDW+1)'(i);
      end
    end
    if (sel_sum >= N_W) begin
      sel_sum = sel_sum - N_W;
    end
    sel_id = sel_sum[IDW-1:0];
  end

  // Next-state and next-output logic for the IDLE/GRANT/RELEASE cycle
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          gnt_d       = N'(1) << sel_id;
          gnt_valid_d = 1'b1;
          gnt_id_d    = sel_id;
          cnt_d       = 8'd1;
          state_d     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (owner_done || !owner_req || (cnt_q == HOLD_LIM)) begin
          // Done or dropped request takes priority over the hold limit
          timeout_d   = !(owner_done || !owner_req);
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = ptr_next;
          cnt_d       = 8'd0;
          state_d     = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      cnt_q       <= 8'd0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_valid = gnt_valid_q;
  assign o_gnt_id    = gnt_id_q;
  assign o_timeout   = timeout_q;

endmodule
